// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared constants, digit state type and hex-to-segment table for the scan controller
package seg_scan_ctrl_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_SEL [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // active-low {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data/load handshake and scan outputs between game logic (master) and controller (slave)
//   master drives digits_in[15:0], dp_in[3:0], en_in[3:0], load; reads load_ack, an, seg, dp, digit_idx, frame_start
interface seg_scan_ctrl_if;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_start;
  modport master (output digits_in, dp_in, en_in, load,
                  input load_ack, an, seg, dp, digit_idx, frame_start);
  modport slave (input digits_in, dp_in, en_in, load,
                 output load_ack, an, seg, dp, digit_idx, frame_start);
endinterface

// File: rtl/seg_scan_ctrl_seg7_decode.sv
// seg_scan_ctrl_seg7_decode: combinational hex nibble to active-low seven-segment pattern
//   i_nib[3:0] hex value in, o_seg[6:0] {g..a} active-low out
module seg_scan_ctrl_seg7_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scanner with blanking gap and frame-synchronous double buffer
//   clk, rst (async, active-high); bus: seg_scan_ctrl_if.slave carrying load handshake in and an/seg/dp/digit_idx/frame_start out
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 32768,
  parameter int unsigned BLANK_CYC = 256
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] r_cnt;
  digit_e        r_digit, w_digit_nxt;
  logic [15:0]   r_act_d, r_pend_d;
  logic [3:0]    r_act_dp, r_act_en, r_pend_dp, r_pend_en;
  logic          r_pend_v;
  logic          w_slot_end, w_wrap, w_show;
  logic [6:0]    w_seg;
  assign w_slot_end = r_cnt == CW'(SCAN_DIV - 1);
  // the frame boundary is the last cycle of digit 3's slot
  assign w_wrap = w_slot_end && r_digit == DIG3;
  assign w_show = 32'(r_cnt) >= BLANK_CYC && r_act_en[r_digit];
  assign bus.digit_idx = r_digit;
  always_comb w_digit_nxt = w_slot_end ? digit_e'(r_digit + 2'd1) : r_digit;
  seg_scan_ctrl_seg7_decode u_dec (
    .i_nib (r_act_d[{r_digit, 2'b00} +: 4]),
    .o_seg (w_seg)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_digit <= DIG0;
    end else begin
      r_cnt   <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_digit <= w_digit_nxt;
    end
  end
  // a load coinciding with the wrap bypasses pending so the new data still lands in this frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_act_d, r_act_dp, r_act_en}    <= '0;
      {r_pend_d, r_pend_dp, r_pend_en} <= '0;
      r_pend_v        <= 1'b0;
      bus.load_ack    <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      if (bus.load) {r_pend_d, r_pend_dp, r_pend_en} <= {bus.digits_in, bus.dp_in, bus.en_in};
      if (w_wrap && bus.load) {r_act_d, r_act_dp, r_act_en} <= {bus.digits_in, bus.dp_in, bus.en_in};
      else if (w_wrap && r_pend_v) {r_act_d, r_act_dp, r_act_en} <= {r_pend_d, r_pend_dp, r_pend_en};
      r_pend_v        <= w_wrap ? 1'b0 : (r_pend_v || bus.load);
      bus.load_ack    <= w_wrap && (bus.load || r_pend_v);
      bus.frame_start <= w_wrap;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an  <= ANODE_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= w_show ? ANODE_SEL[r_digit] : ANODE_OFF;
      bus.seg <= w_show ? w_seg : SEG_BLANK;
      bus.dp  <= ~(w_show && r_act_dp[r_digit]);
    end
  end
endmodule
